// File: rtl/traffic_pkg.sv
// Shared types and constants for the highway/country-road intersection controller.
// Signal-head colour codes, the FSM state encoding and the default phase delays.
package traffic_pkg;

  localparam logic [1:0] RED    = 2'b00;
  localparam logic [1:0] YELLOW = 2'b01;
  localparam logic [1:0] GREEN  = 2'b10;

  typedef enum logic [2:0] {
    S0 = 3'd0,  // HWY_GREEN
    S1 = 3'd1,  // HWY_YELLOW
    S2 = 3'd2,  // ALL_RED
    S3 = 3'd3,  // CRD_GREEN
    S4 = 3'd4   // CRD_YELLOW
  } state_t;

  localparam int Y2RDELAY_DEF = 3;
  localparam int R2GDELAY_DEF = 2;
  localparam int CNT_W_DEF    = 4;

endpackage

// File: rtl/traffic_control.sv
// Moore FSM for a highway / country-road intersection: highway green by default,
// country road served while cars wait, with timed yellow and all-red phases.
module traffic_control
  import traffic_pkg::*;
#(
  parameter int Y2RDELAY = Y2RDELAY_DEF,
  parameter int R2GDELAY = R2GDELAY_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic       clk,
  input  logic       clear,
  input  logic       car_on_croad,
  output logic [1:0] hwrd_sig,
  output logic [1:0] crd_sig
);

  // A timed phase ends on the edge where the counter reaches delay-1.
  localparam logic [CNT_W-1:0] Y2R_LAST = CNT_W'(Y2RDELAY - 1);
  localparam logic [CNT_W-1:0] R2G_LAST = CNT_W'(R2GDELAY - 1);

  state_t           state_reg;
  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state_reg <= S0;
      cnt_reg   <= '0;
    end else begin
      case (state_reg)
        S0: begin
          cnt_reg <= '0;
          if (car_on_croad) state_reg <= S1;
        end
        S1: begin
          if (cnt_reg == Y2R_LAST) begin
            state_reg <= S2;
            cnt_reg   <= '0;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        S2: begin
          if (cnt_reg == R2G_LAST) begin
            state_reg <= S3;
            cnt_reg   <= '0;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        S3: begin
          cnt_reg <= '0;
          if (!car_on_croad) state_reg <= S4;
        end
        S4: begin
          // Cars arriving here are not remembered; S0 samples them again.
          if (cnt_reg == Y2R_LAST) begin
            state_reg <= S0;
            cnt_reg   <= '0;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        default: begin
          state_reg <= S0;
          cnt_reg   <= '0;
        end
      endcase
    end
  end

  // Lamp codes depend on the state register alone; stray encodings show all red.
  always_comb begin
    hwrd_sig = RED;
    crd_sig  = RED;
    case (state_reg)
      S0:      hwrd_sig = GREEN;
      S1:      hwrd_sig = YELLOW;
      S3:      crd_sig  = GREEN;
      S4:      crd_sig  = YELLOW;
      default: begin
        hwrd_sig = RED;
        crd_sig  = RED;
      end
    endcase
  end

endmodule

// File: tb/tb_traffic_control.sv
// Directed bench for traffic_control: default-delay instance plus a Y2R=1/R2G=4
// instance; expected lamp codes are written as {hwrd_sig, crd_sig}.
module tb_traffic_control;

  logic       clk = 1'b0;
  logic       clear = 1'b1;
  logic       car_a = 1'b0;
  logic       car_b = 1'b0;
  logic [1:0] hwrd_a, crd_a, hwrd_b, crd_b;

  int n_tests = 0;
  int n_fail  = 0;
  bit safety_on = 1'b0;

  always #5 clk = ~clk;

  traffic_control dut_a (
    .clk          (clk),
    .clear        (clear),
    .car_on_croad (car_a),
    .hwrd_sig     (hwrd_a),
    .crd_sig      (crd_a)
  );

  traffic_control #(.Y2RDELAY(1), .R2GDELAY(4), .CNT_W(4)) dut_b (
    .clk          (clk),
    .clear        (clear),
    .car_on_croad (car_b),
    .hwrd_sig     (hwrd_b),
    .crd_sig      (crd_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
    end else begin
      $display("[TB] ok   %s: %0h at %0t", tag, obs, $time);
    end
  endtask

  // One clock of dut_a with its car input; dut_b idles with no car.
  task automatic step_a(input string tag, input logic c, input logic [3:0] exp);
    car_a = c;
    car_b = 1'b0;
    @(posedge clk);
    #1;
    check(tag, {28'd0, hwrd_a, crd_a}, {28'd0, exp});
  endtask

  task automatic step_b(input string tag, input logic c, input logic [3:0] exp);
    car_b = c;
    car_a = 1'b0;
    @(posedge clk);
    #1;
    check(tag, {28'd0, hwrd_b, crd_b}, {28'd0, exp});
  endtask

  // Safety: never both heads non-red, never code 2'b11, on either instance.
  always @(negedge clk) begin
    if (safety_on) begin
      check("safe_a", {31'd0, (hwrd_a != 2'b00 && crd_a != 2'b00) || hwrd_a == 2'b11 || crd_a == 2'b11}, 32'd0);
      check("safe_b", {31'd0, (hwrd_b != 2'b00 && crd_b != 2'b00) || hwrd_b == 2'b11 || crd_b == 2'b11}, 32'd0);
    end
  end

  initial begin
    #2 clear = 1'b0;

    // 1: reset hold, then idle highway green
    for (int i = 0; i < 5; i++) step_a("rst_hold", 1'b0, 4'b1000);
    check("rst_b", {28'd0, hwrd_b, crd_b}, 32'h8);
    #3 clear = 1'b1;
    safety_on = 1'b1;
    for (int i = 0; i < 20; i++) step_a("idle", 1'b0, 4'b1000);

    // 2: full cycle with car present for 10 edges
    for (int i = 0; i < 10; i++)
      step_a("full_car", 1'b1, (i < 3) ? 4'b0100 : (i < 5) ? 4'b0000 : 4'b0010);
    for (int i = 0; i < 3; i++) step_a("full_cyel", 1'b0, 4'b0001);
    step_a("full_back", 1'b0, 4'b1000);
    step_a("full_idle", 1'b0, 4'b1000);

    // 3: single-cycle pulse; S3 lasts one cycle
    step_a("pulse_s1", 1'b1, 4'b0100);
    step_a("pulse_s1", 1'b0, 4'b0100);
    step_a("pulse_s1", 1'b0, 4'b0100);
    step_a("pulse_s2", 1'b0, 4'b0000);
    step_a("pulse_s2", 1'b0, 4'b0000);
    step_a("pulse_s3", 1'b0, 4'b0010);
    for (int i = 0; i < 3; i++) step_a("pulse_s4", 1'b0, 4'b0001);
    step_a("pulse_s0", 1'b0, 4'b1000);

    // 4: car activity during S1/S2/S4 does not alter timing; lingering car restarts
    step_a("late_s1", 1'b1, 4'b0100);
    step_a("late_s1", 1'b1, 4'b0100);
    step_a("late_s1", 1'b1, 4'b0100);
    step_a("late_s2", 1'b0, 4'b0000);
    step_a("late_s2", 1'b0, 4'b0000);
    step_a("late_s3", 1'b0, 4'b0010);
    step_a("late_s4", 1'b0, 4'b0001);
    step_a("late_s4", 1'b1, 4'b0001);
    step_a("late_s4", 1'b1, 4'b0001);
    step_a("late_s0", 1'b1, 4'b1000);
    step_a("late_re_s1", 1'b1, 4'b0100);
    step_a("late_re_s1", 1'b0, 4'b0100);
    step_a("late_re_s1", 1'b0, 4'b0100);
    step_a("late_re_s2", 1'b0, 4'b0000);
    step_a("late_re_s2", 1'b0, 4'b0000);
    step_a("late_re_s3", 1'b0, 4'b0010);
    for (int i = 0; i < 3; i++) step_a("late_re_s4", 1'b0, 4'b0001);
    step_a("late_re_s0", 1'b0, 4'b1000);

    // 5: asynchronous reset while in S3
    for (int i = 0; i < 7; i++)
      step_a("mid_run", 1'b1, (i < 3) ? 4'b0100 : (i < 5) ? 4'b0000 : 4'b0010);
    #3 clear = 1'b0;
    #1 check("mid_async", {28'd0, hwrd_a, crd_a}, 32'h8);
    for (int i = 0; i < 3; i++) step_a("mid_hold", 1'b1, 4'b1000);
    #4 clear = 1'b1;
    step_a("mid_rel", 1'b0, 4'b1000);
    step_a("mid_restart", 1'b1, 4'b0100);
    step_a("mid_s1", 1'b0, 4'b0100);
    step_a("mid_s1", 1'b0, 4'b0100);
    step_a("mid_s2", 1'b0, 4'b0000);
    step_a("mid_s2", 1'b0, 4'b0000);
    step_a("mid_s3", 1'b0, 4'b0010);
    for (int i = 0; i < 3; i++) step_a("mid_s4", 1'b0, 4'b0001);
    step_a("mid_s0", 1'b0, 4'b1000);

    // 6: overridden delays, Y2R=1, R2G=4
    step_b("ovr_s1", 1'b1, 4'b0100);
    for (int i = 0; i < 4; i++) step_b("ovr_s2", 1'b0, 4'b0000);
    step_b("ovr_s3", 1'b0, 4'b0010);
    step_b("ovr_s4", 1'b0, 4'b0001);
    step_b("ovr_s0", 1'b0, 4'b1000);
    step_b("ovr_idle", 1'b0, 4'b1000);
    step_b("ovr_hold_s1", 1'b1, 4'b0100);
    for (int i = 0; i < 4; i++) step_b("ovr_hold_s2", 1'b1, 4'b0000);
    step_b("ovr_hold_s3", 1'b1, 4'b0010);
    step_b("ovr_hold_s3", 1'b1, 4'b0010);
    step_b("ovr_hold_s4", 1'b0, 4'b0001);
    step_b("ovr_hold_s0", 1'b0, 4'b1000);

    safety_on = 1'b0;
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
